// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects/extends the result, then queues it in a DEPTH-entry FIFO toward the register file.
// Optional macro WB_MISALIGN_TRAP_EN adds misaligned-load flagging (o_misalign) that suppresses the write.
module wb_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_wb_sel,
    input  logic [2:0]       i_ld_rewrite,
    input  logic [XLEN-1:0]  i_pc_four,
    input  logic [XLEN-1:0]  i_alu_data,
    input  logic [XLEN-1:0]  i_ld_data,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_rd_wren,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_wb_data,
    output logic [4:0]       o_rd_addr,
    output logic             o_rd_wren,
`ifdef WB_MISALIGN_TRAP_EN
    output logic             o_misalign,
`endif
    output logic [CNT_W-1:0] o_retire_cnt
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  byte_sh, half_sh, word_sh;
    logic [XLEN-1:0]  ld_val, src_val, data_in;
    logic             wren_in;

    assign off     = i_alu_data[OFF_W-1:0];
    assign byte_sh = i_ld_data >> (8 * int'(off));
    assign half_sh = i_ld_data >> (16 * int'(off >> 1));
    assign word_sh = i_ld_data >> (32 * int'(off >> 2));

    // Codes 5/6 only have a distinct meaning on a 64-bit datapath; otherwise they behave as LW.
    always_comb begin
        ld_val = '0;
        case (i_ld_rewrite)
            3'd0:    ld_val = XLEN'($signed(byte_sh[7:0]));
            3'd1:    ld_val = XLEN'($signed(half_sh[15:0]));
            3'd3:    ld_val = XLEN'(byte_sh[7:0]);
            3'd4:    ld_val = XLEN'(half_sh[15:0]);
            3'd5:    ld_val = (XLEN == 64) ? XLEN'(word_sh[31:0]) : XLEN'($signed(word_sh[31:0]));
            3'd6:    ld_val = (XLEN == 64) ? i_ld_data : XLEN'($signed(word_sh[31:0]));
            default: ld_val = XLEN'($signed(word_sh[31:0]));
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    logic mis_in;
    always_comb begin
        mis_in = 1'b0;
        case (i_ld_rewrite)
            3'd0, 3'd3: mis_in = 1'b0;
            3'd1, 3'd4: mis_in = off[0];
            3'd5, 3'd6: mis_in = (XLEN == 64 && i_ld_rewrite == 3'd6) ? (off != '0) : (off[1:0] != 2'b00);
            default:    mis_in = (off[1:0] != 2'b00);
        endcase
        if (i_wb_sel != 2'd2) mis_in = 1'b0;
    end
`endif

    always_comb begin
        src_val = '0;
        case (i_wb_sel)
            2'd0:    src_val = i_pc_four;
            2'd1:    src_val = i_alu_data;
            2'd2:    src_val = ld_val;
            default: src_val = '0;
        endcase
        data_in = (i_rd_addr == 5'd0) ? '0 : src_val;
        wren_in = i_rd_wren && (i_rd_addr != 5'd0);
`ifdef WB_MISALIGN_TRAP_EN
        if (mis_in) wren_in = 1'b0;
`endif
    end

    // Both sides: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [4:0]       rd_mem   [DEPTH];
    logic             wren_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             push, pop;

    assign o_ready = (count_q != FULL_CNT);
    assign o_valid = (count_q != '0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        retire_d = pop  ? retire_q + CNT_W'(1) : retire_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CNT_ONE;
        if (pop && !push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            retire_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            retire_q <= retire_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            data_mem[wr_ptr_q] <= data_in;
            rd_mem[wr_ptr_q]   <= i_rd_addr;
            wren_mem[wr_ptr_q] <= wren_in;
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    logic mis_mem [DEPTH];
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) mis_mem[wr_ptr_q] <= mis_in;
    end
    assign o_misalign = o_valid ? mis_mem[rd_ptr_q] : 1'b0;
`endif

    assign o_wb_data    = o_valid ? data_mem[rd_ptr_q] : '0;
    assign o_rd_addr    = o_valid ? rd_mem[rd_ptr_q]   : 5'd0;
    assign o_rd_wren    = o_valid ? wren_mem[rd_ptr_q] : 1'b0;
    assign o_retire_cnt = retire_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe (XLEN=32, DEPTH=2); define WB_MISALIGN_TRAP_EN to build the trap variant.
module tb_wb_stage_pipe;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 32;
    localparam int EW    = XLEN + 7;
`ifdef WB_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst, i_valid, i_ready, i_rd_wren;
    logic [1:0]       i_wb_sel;
    logic [2:0]       i_ld_rewrite;
    logic [XLEN-1:0]  i_pc_four, i_alu_data, i_ld_data;
    logic [4:0]       i_rd_addr;
    logic             o_ready, o_valid, o_rd_wren;
    logic [XLEN-1:0]  o_wb_data;
    logic [4:0]       o_rd_addr;
    logic [CNT_W-1:0] o_retire_cnt;
`ifdef WB_MISALIGN_TRAP_EN
    logic             o_misalign;
`endif

    wb_stage_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_wb_sel(i_wb_sel), .i_ld_rewrite(i_ld_rewrite), .i_pc_four(i_pc_four),
        .i_alu_data(i_alu_data), .i_ld_data(i_ld_data), .i_rd_addr(i_rd_addr),
        .i_rd_wren(i_rd_wren), .o_valid(o_valid), .i_ready(i_ready),
        .o_wb_data(o_wb_data), .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren),
`ifdef WB_MISALIGN_TRAP_EN
        .o_misalign(o_misalign),
`endif
        .o_retire_cnt(o_retire_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0]    exp_q[$];
    logic [CNT_W-1:0] exp_retire = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] ld,
                          input logic [31:0] alu, input logic [4:0] rd);
        i_wb_sel     = sel;
        i_ld_rewrite = lt;
        i_ld_data    = ld;
        i_alu_data   = alu;
        i_rd_addr    = rd;
        i_rd_wren    = 1'b1;
    endtask

    task automatic enq(input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] ld,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [XLEN-1:0] exp_data,
                       input logic exp_wren, input logic exp_mis);
        set_in(sel, lt, ld, alu, rd);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        exp_q.push_back({exp_data, rd, exp_wren, exp_mis});
    endtask

    task automatic check_head(input string tag);
        logic [EW-1:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        check({tag, ".valid"}, 64'(o_valid), 64'(exp_q.size() != 0));
        check({tag, ".data"},  64'(o_wb_data), 64'(e[EW-1:7]));
        check({tag, ".rd"},    64'(o_rd_addr), 64'(e[6:2]));
        check({tag, ".wren"},  64'(o_rd_wren), 64'(e[1]));
`ifdef WB_MISALIGN_TRAP_EN
        check({tag, ".mis"},   64'(o_misalign), 64'(e[0]));
`endif
    endtask

    task automatic deq(input string tag);
        check_head(tag);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_retire++;
        check({tag, ".retire"}, 64'(o_retire_cnt), 64'(exp_retire));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_q.delete();
        exp_retire = '0;
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_pc_four = 32'h0000_1004;
        set_in(2'd0, 3'd0, '0, '0, 5'd0);
        tick();
        do_reset();
        check("rst.valid", 64'(o_valid), 64'd0);
        check("rst.ready", 64'(o_ready), 64'd1);
        check("rst.retire", 64'(o_retire_cnt), 64'd0);
        check("rst.data", 64'(o_wb_data), 64'd0);

        // load extraction vectors: sel, type, ld_data, alu(addr), rd, expected data, wren, misalign
        enq(2'd2, 3'd0, 32'hAABBCCDD, 32'h87654321, 5'd5, 32'hFFFFFFCC, 1'b1, 1'b0);  deq("lb_off1");
        enq(2'd2, 3'd4, 32'hAABBCCDD, 32'h87654322, 5'd6, 32'h0000AABB, 1'b1, 1'b0);  deq("lhu_off2");
        enq(2'd2, 3'd1, 32'hAABBCCDD, 32'h87654322, 5'd7, 32'hFFFFAABB, 1'b1, 1'b0);  deq("lh_off2");
        enq(2'd2, 3'd3, 32'hAABBCCDD, 32'h87654323, 5'd8, 32'h000000AA, 1'b1, 1'b0);  deq("lbu_off3");
        enq(2'd2, 3'd0, 32'hAABBCCDD, 32'h00000000, 5'd9, 32'hFFFFFFDD, 1'b1, 1'b0);  deq("lb_off0");
        enq(2'd2, 3'd3, 32'h11223344, 32'h00000002, 5'd9, 32'h00000022, 1'b1, 1'b0);  deq("lbu_off2");
        enq(2'd2, 3'd2, 32'h80000001, 32'h00000000, 5'd10, 32'h80000001, 1'b1, 1'b0); deq("lw");
        enq(2'd2, 3'd5, 32'h80000001, 32'h00000004, 5'd11, 32'h80000001, 1'b1, 1'b0); deq("lwu_as_lw");
        enq(2'd2, 3'd6, 32'h80000001, 32'h00000008, 5'd12, 32'h80000001, 1'b1, 1'b0); deq("ld_as_lw");
        enq(2'd2, 3'd7, 32'h7FFF0000, 32'h00000000, 5'd13, 32'h7FFF0000, 1'b1, 1'b0); deq("code7_lw");
        enq(2'd2, 3'd2, 32'hAABBCCDD, 32'h87654321, 5'd14, 32'hAABBCCDD, !TRAP, TRAP); deq("lw_misal");
        enq(2'd2, 3'd1, 32'hAABBCCDD, 32'h87654321, 5'd15, 32'hFFFFCCDD, !TRAP, TRAP); deq("lh_misal");
        enq(2'd1, 3'd2, 32'hAABBCCDD, 32'h87654321, 5'd16, 32'h87654321, 1'b1, 1'b0); deq("alu_misal_addr");
        enq(2'd1, 3'd0, 32'h0, 32'h12345678, 5'd0, 32'h00000000, 1'b0, 1'b0);         deq("rd0");
        enq(2'd0, 3'd0, 32'h0, 32'h12345678, 5'd17, 32'h00001004, 1'b1, 1'b0);        deq("pc_four");
        enq(2'd3, 3'd0, 32'h0, 32'h12345678, 5'd18, 32'h00000000, 1'b1, 1'b0);        deq("zero");
        check("empty.valid", 64'(o_valid), 64'd0);

        // simultaneous push and pop with one entry queued
        enq(2'd1, 3'd0, 32'h0, 32'h0000AAAA, 5'd1, 32'h0000AAAA, 1'b1, 1'b0);
        check_head("pp.before");
        set_in(2'd1, 3'd0, 32'h0, 32'h0000BBBB, 5'd2);
        i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0; i_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({32'h0000BBBB, 5'd2, 1'b1, 1'b0});
        exp_retire++;
        check("pp.retire", 64'(o_retire_cnt), 64'(exp_retire));
        check("pp.ready", 64'(o_ready), 64'd1);
        deq("pp.after");

        // fill with downstream stalled, third push must be refused
        do_reset();
        enq(2'd1, 3'd0, 32'h0, 32'h00000A01, 5'd3, 32'h00000A01, 1'b1, 1'b0);
        check("fill1.ready", 64'(o_ready), 64'd1);
        enq(2'd1, 3'd0, 32'h0, 32'h00000A02, 5'd4, 32'h00000A02, 1'b1, 1'b0);
        check("full.ready", 64'(o_ready), 64'd0);
        set_in(2'd1, 3'd0, 32'h0, 32'h00000A03, 5'd5);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("stall.ready", 64'(o_ready), 64'd0);
        check_head("stall.hold");
        deq("pop1");
        deq("pop2");
        check("drain.valid", 64'(o_valid), 64'd0);
        check("drain.retire", 64'(o_retire_cnt), 64'd2);

        // reset with two entries in flight and push/pop both requested
        enq(2'd1, 3'd0, 32'h0, 32'h00000B01, 5'd6, 32'h00000B01, 1'b1, 1'b0);
        enq(2'd1, 3'd0, 32'h0, 32'h00000B02, 5'd7, 32'h00000B02, 1'b1, 1'b0);
        i_valid = 1'b1; i_ready = 1'b1;
        do_reset();
        i_valid = 1'b0; i_ready = 1'b0;
        check("rst2.valid", 64'(o_valid), 64'd0);
        check("rst2.ready", 64'(o_ready), 64'd1);
        check("rst2.retire", 64'(o_retire_cnt), 64'd0);
        check("rst2.data", 64'(o_wb_data), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL provide parameter DEPTH, default 2, result-buffer entries; power of two, >= 2.
REQ-003 SHALL provide parameter CNT_W, default 32, retire-counter width.
REQ-004 SHALL provide port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL provide port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide ports i_valid  input  1 and o_ready  output  1  upstream handshake.
REQ-007 SHALL provide port i_wb_sel  input  2  source select: 0 pc_four, 1 alu, 2 load, 3 zero.
REQ-008 SHALL provide port i_ld_rewrite  input  3  load type: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 LWU, 6 LD.
REQ-009 SHALL provide ports i_pc_four, i_alu_data, i_ld_data  input  XLEN each  candidate sources; i_alu_data carries the load address.
REQ-010 SHALL provide ports i_rd_addr  input  5 and i_rd_wren  input  1  destination register and write request.
REQ-011 SHALL provide ports o_valid  output  1 and i_ready  input  1  downstream (register-file) handshake.
REQ-012 SHALL provide ports o_wb_data  output  XLEN, o_rd_addr  output  5, o_rd_wren  output  1  head-entry writeback.
REQ-013 SHALL provide port o_retire_cnt  output  CNT_W  count of popped entries.
REQ-014 SHALL provide port o_misalign  output  1  head entry was a misaligned load (WB_MISALIGN_TRAP_EN only).

Function
REQ-015 SHALL compute byte offset off = i_alu_data[log2(XLEN/8)-1:0] combinationally at input.
REQ-016 SHALL select LB/LBU byte = i_ld_data[8*off +: 8], LH/LHU half = i_ld_data[16*(off>>1) +: 16], LW/LWU word = i_ld_data[32*(off>>2) +: 32], LD = i_ld_data.
REQ-017 SHALL sign-extend LB/LH/LW and zero-extend LBU/LHU/LWU to XLEN.
REQ-018 SHALL treat codes 5, 6 as LW when XLEN=32 and code 7 as LW for any XLEN.
REQ-019 SHALL force stored wren=0 and data=0 when i_rd_addr==0.
REQ-020 SHALL push {data, rd_addr, wren, misalign} into a DEPTH-entry FIFO when i_valid && o_ready.
REQ-021 SHALL drive o_ready = !full; no same-cycle pass-through when full.
REQ-022 SHALL drive o_valid = !empty; o_wb_data/o_rd_addr/o_rd_wren/o_misalign show head entry; all 0 when empty.
REQ-023 SHALL pop head when o_valid && i_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-024 SHALL give latency one cycle: entry pushed at edge N is visible on o_valid after edge N.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; occupancy counter range 0..DEPTH.
REQ-026 SHALL hold head outputs stable while o_valid && !i_ready.
REQ-027 SHALL increment o_retire_cnt by 1 per pop, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-028 SHALL, when i_rst=1 at a rising edge, clear FIFO pointers and occupancy, o_valid=0, o_ready=1, o_retire_cnt=0, o_misalign=0.
REQ-029 SHALL give i_rst priority over simultaneous push/pop; in-flight entries are discarded.

Configuration
REQ-030 SHALL, with WB_MISALIGN_TRAP_EN defined, flag misalign for LH/LHU off[0]!=0, LW/LWU off[1:0]!=0, LD off!=0, and force that entry's wren=0.
REQ-031 SHALL, without WB_MISALIGN_TRAP_EN, omit o_misalign and the flag storage; misaligned loads proceed with REQ-016 selection and wren unchanged.

Verification
REQ-032 SHALL cover: XLEN=32, ld_data=AABBCCDD, alu=87654321, LB, rd=5 -> o_wb_data=FFFFFFCC, o_rd_wren=1 one cycle later.
REQ-033 SHALL cover: alu=87654322, LHU -> 0000AABB; LH -> FFFFAABB; LBU off=3 -> 000000AA.
REQ-034 SHALL cover: DEPTH=2, i_ready=0, three back-to-back pushes -> third stalls (o_ready=0); i_ready=1 -> pops in order, o_retire_cnt=2.
REQ-035 SHALL cover: rd=0 with wb_sel=1, alu=12345678 -> o_rd_wren=0, o_wb_data=0.
REQ-036 SHALL cover: WB_MISALIGN_TRAP_EN, LW with alu=...01 -> o_misalign=1, o_rd_wren=0; without macro -> wren=1.
REQ-037 SHALL cover: i_rst asserted with 2 entries queued -> next cycle o_valid=0, o_ready=1, o_retire_cnt=0.
